// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_BUSY,
    RS_RESP
  } resp_state_e;

  // Natural alignment check; byte accesses are always aligned.
  function automatic logic is_aligned(input logic [2:0] width, input logic [1:0] addr_lo);
    case (width)
      MW_H, MW_HU: return ~addr_lo[0];
      MW_W:        return (addr_lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

  // Unsigned widths only make sense for loads.
  function automatic logic is_legal(input logic [2:0] width, input logic write);
    case (width)
      MW_B, MW_H, MW_W: return 1'b1;
      MW_BU, MW_HU:     return ~write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: store byte enables / replicated write word, load shift and extension.
module lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_word,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata_word >> {addr_lo, 3'b000};

  // Decode width into lanes; illegal codes produce no enables and zero data.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_word = 32'h0;
    rdata_ext  = 32'h0;
    case (funct3)
      MW_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_word = {4{wdata[7:0]}};
        rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
      end
      MW_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_word = {4{wdata[7:0]}};
        rdata_ext  = {24'h0, shifted[7:0]};
      end
      MW_H: begin
        byte_en    = 4'b0011 << addr_lo;
        wdata_word = {2{wdata[15:0]}};
        rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
      end
      MW_HU: begin
        byte_en    = 4'b0011 << addr_lo;
        wdata_word = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, shifted[15:0]};
      end
      MW_W: begin
        byte_en    = 4'b1111;
        wdata_word = wdata;
        rdata_ext  = shifted;
      end
      default: begin
        byte_en    = 4'b0000;
        wdata_word = 32'h0;
        rdata_ext  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with fixed response latency in front of a word-organised RAM.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  RS_IDLE | ready for a request; stores commit on the accept edge
//  RS_BUSY | latency counter running down toward the response
//  RS_RESP | response held on resp_* until the initiator takes it
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  resp_state_e state, state_nxt;
  logic [3:0]  cnt;

  logic                  cap_write;
  logic                  cap_err;
  logic [2:0]            cap_funct3;
  logic [1:0]            cap_lo;
  logic [ADDR_WIDTH-3:0] cap_idx;

  logic [31:0] mem [WORDS];

  logic                  accept;
  logic                  req_err;
  logic                  in_idle;
  logic                  cur_write;
  logic                  cur_err;
  logic [2:0]            cur_funct3;
  logic [1:0]            cur_lo;
  logic [ADDR_WIDTH-3:0] cur_idx;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_word;
  logic [31:0]           rdata_ext;

  assign accept  = req_valid & req_ready;
  assign req_err = ~is_legal(req_funct3, req_write)
                 | ~is_aligned(req_funct3, req_addr[1:0])
                 | (|req_addr[31:ADDR_WIDTH]);

  // Live request fields in IDLE (store commit, or load read when LATENCY=1), captured ones after.
  assign in_idle    = (state == RS_IDLE);
  assign cur_write  = in_idle ? req_write  : cap_write;
  assign cur_err    = in_idle ? req_err    : cap_err;
  assign cur_funct3 = in_idle ? req_funct3 : cap_funct3;
  assign cur_lo     = in_idle ? req_addr[1:0] : cap_lo;
  assign cur_idx    = in_idle ? req_addr[ADDR_WIDTH-1:2] : cap_idx;

  lane_align u_lane_align (
    .funct3     (cur_funct3),
    .addr_lo    (cur_lo),
    .wdata      (req_wdata),
    .rdata_word (mem[cur_idx]),
    .byte_en    (byte_en),
    .wdata_word (wdata_word),
    .rdata_ext  (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RS_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      RS_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (CNT_LOAD == 4'd0) ? RS_RESP : RS_BUSY;
      end
      RS_BUSY: begin
        if (cnt == 4'd1) state_nxt = RS_RESP;
      end
      RS_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = RS_IDLE;
      end
      default: state_nxt = RS_IDLE;
    endcase
  end

  // Request capture, latency counter and registered response payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 4'd0;
      cap_write  <= 1'b0;
      cap_err    <= 1'b0;
      cap_funct3 <= 3'b000;
      cap_lo     <= 2'b00;
      cap_idx    <= '0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= CNT_LOAD;
        cap_write  <= req_write;
        cap_err    <= req_err;
        cap_funct3 <= req_funct3;
        cap_lo     <= req_addr[1:0];
        cap_idx    <= req_addr[ADDR_WIDTH-1:2];
      end else if (state == RS_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (state_nxt == RS_RESP && state != RS_RESP) begin
        resp_rdata <= (cur_write | cur_err) ? 32'h0 : rdata_ext;
        resp_error <= cur_err;
      end else if (resp_valid && resp_ready) begin
        resp_rdata <= 32'h0;
        resp_error <= 1'b0;
      end
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[cur_idx][8*i +: 8] <= wdata_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2, 1 and 4.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [31:0] resp_rdata [3];

  int n_checks = 0;
  int n_fail   = 0;
  int lat [3]  = '{2, 1, 4};

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_funct3(req_funct3[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k; hold = cycles of resp backpressure after resp_valid.
  task automatic xact(input int k, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int hold);
    int          n;
    logic [31:0] rd0;
    logic        e0;
    @(negedge clk);
    check_val("req_ready idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_write[k] = wr; req_funct3[k] = f3;
    req_addr[k] = addr; req_wdata[k] = wd;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_write[k] = ~wr; req_funct3[k] = 3'b011;
    req_addr[k] = $urandom; req_wdata[k] = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid[k] && n < 40);
    check_val("latency", 32'(n), 32'(lat[k]));
    if (!resp_valid[k]) begin
      check_val("resp_valid timeout", 32'd0, 32'd1);
      return;
    end
    check_val("rdata", resp_rdata[k], exp_rd);
    check_val("error", 32'(resp_error[k]), 32'(exp_err));
    rd0 = resp_rdata[k];
    e0  = resp_error[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold valid", 32'(resp_valid[k]), 32'd1);
      check_val("hold rdata", resp_rdata[k], rd0);
      check_val("hold error", 32'(resp_error[k]), 32'(e0));
      check_val("hold req_ready", 32'(req_ready[k]), 32'd0);
    end
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[k] = 1'b0;
    req_valid[k]  = 1'b0;
    check_val("post-hs resp_valid", 32'(resp_valid[k]), 32'd0);
    check_val("post-hs req_ready", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; resp_ready[k] = 1'b0;
      req_funct3[k] = 3'b000; req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val("reset req_ready", 32'(req_ready[k]), 32'd1);
      check_val("reset resp_valid", 32'(resp_valid[k]), 32'd0);
      check_val("reset rdata", resp_rdata[k], 32'h0);
      check_val("reset error", 32'(resp_error[k]), 32'd0);
    end
    reset = 1'b1;

    // Word store/load
    xact(0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte store and extensions
    xact(0, 1'b1, 3'b000, 32'h013, 32'hAAAAAA80, 32'h0, 1'b0, 0);
    xact(0, 1'b0, 3'b000, 32'h013, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    xact(0, 1'b0, 3'b100, 32'h013, 32'h0, 32'h00000080, 1'b0, 0);
    xact(0, 1'b0, 3'b010, 32'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
    xact(0, 1'b0, 3'b001, 32'h012, 32'h0, 32'hFFFF80AD, 1'b0, 0);
    xact(0, 1'b0, 3'b101, 32'h010, 32'h0, 32'h0000BEEF, 1'b0, 0);

    // Errors
    xact(0, 1'b1, 3'b001, 32'h011, 32'h1234, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 3'b010, 32'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
    xact(0, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b1, 3'b100, 32'h010, 32'h55, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 3'b011, 32'h010, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 3'b010, 32'h012, 32'h0, 32'h0, 1'b1, 0);
    xact(0, 1'b0, 3'b010, 32'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);

    // Backpressure at each latency
    xact(0, 1'b0, 3'b010, 32'h010, 32'h0, 32'h80ADBEEF, 1'b0, 5);
    xact(1, 1'b1, 3'b010, 32'h020, 32'h11223344, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 3'b001, 32'h022, 32'h0, 32'h00001122, 1'b0, 5);
    xact(1, 1'b0, 3'b000, 32'h021, 32'h0, 32'h00000033, 1'b0, 0);
    xact(2, 1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    xact(2, 1'b0, 3'b101, 32'h3FE, 32'h0, 32'h0000CAFE, 1'b0, 5);
    xact(2, 1'b0, 3'b000, 32'h3FD, 32'h0, 32'hFFFFFFF0, 1'b0, 0);

    // Reset while BUSY
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_funct3[2] = 3'b010; req_addr[2] = 32'h3FC;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check_val("busy req_ready", 32'(req_ready[2]), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst resp_valid", 32'(resp_valid[2]), 32'd0);
    check_val("rst req_ready", 32'(req_ready[2]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_val("no stale resp", 32'(resp_valid[2]), 32'd0);
    xact(2, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    xact(0, 1'b0, 3'b010, 32'h010, 32'h0, 32'h80ADBEEF, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
